reg_file_2r1w: RTL and testbench
================================

Name: reg_file_2r1w

Overview:
- Parametrised register file for the 6-bit CPU datapath: DEPTH entries of WIDTH bits, one write port and two independent read ports (A, B).
- Successor to the combinational 8-to-1 operand mux. Each read port is an N-to-1 mux with a registered output, so read data is held stable.
- Sits between the decoder (supplies addresses) and the ALU operand inputs.

Parameters:
- WIDTH, 6, data width in bits (1..32).
- DEPTH, 8, number of entries; power of two, 2..64. ADDR_W = $clog2(DEPTH) is a derived localparam.
- ZERO_REG, 0, when 1, entry 0 always reads 0 and ignores writes.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write enable.
- waddr  input  ADDR_W  write address.
- wdata  input  WIDTH  write data.
- re_a  input  1  read enable, port A.
- raddr_a  input  ADDR_W  read address, port A.
- rdata_a  output  WIDTH  registered read data, port A.
- re_b  input  1  read enable, port B.
- raddr_b  input  ADDR_W  read address, port B.
- rdata_b  output  WIDTH  registered read data, port B.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: on a rising edge with rst=1, all DEPTH entries, rdata_a and rdata_b go to 0.
  - rst overrides we, re_a and re_b on that same edge; nothing is written.
  - Asserting rst mid-sequence discards any in-flight read result.
- Write: on a rising edge with rst=0 and we=1, entry[waddr] <= wdata.
  - Exception: with ZERO_REG=1 and waddr=0, the write is dropped.
- Read, each port independent:
  - On a rising edge with rst=0 and re_x=1, rdata_x <= entry[raddr_x]. Latency is exactly 1 cycle.
  - With re_x=0, rdata_x holds its previous value indefinitely.
- Zero register: with ZERO_REG=1 and raddr_x=0, the captured value is 0 regardless of entry contents.
- Read-during-write (same edge, raddr_x == waddr, we=1):
  - Without WR_BYPASS_EN, the old entry value is returned (read-before-write).
  - The new value is visible to a read issued on the next edge.
- Both ports may read the same address on the same edge; both receive identical data.
- Addresses are always in range (DEPTH is a power of two); there is no error path.
- No X propagation from an unwritten entry: every entry is defined after reset.
- Implementation: a flat register array, two DEPTH-to-1 read muxes, and a write-decode enable per entry. No latches.

Optional Feature:
- Macro: RF_WR_BYPASS_EN.
- Defined: write-to-read forwarding. On an edge where we=1, re_x=1 and raddr_x == waddr, rdata_x captures wdata, not the old entry value.
  - Exception: with ZERO_REG=1 and address 0, rdata_x still captures 0.
  - Applies to both ports independently.
- Undefined: read-before-write semantics as described under Behaviour. No extra logic is generated.

Test Plan:
1. Reset then read: assert rst for 2 cycles; read all 8 addresses on both ports -> every rdata = 6'b000000; rdata stays 0 while rst=1 even with re_a=re_b=1.
2. Write/read sweep: write entry[i] = i+1 for i=0..7, then read raddr_a=i, raddr_b=7-i with re=1 -> one cycle later rdata_a=i+1, rdata_b=8-i. Also check hold: with re_a=0 for 3 cycles, rdata_a is unchanged.
3. Read-during-write: entry[3]=6'h05; same edge we=1, waddr=3, wdata=6'h2A, re_a=1, raddr_a=3 -> rdata_a = 6'h05 without the macro, 6'h2A with RF_WR_BYPASS_EN. The next read of 3 returns 6'h2A in both builds.
4. Zero register: ZERO_REG=1; write waddr=0, wdata=6'h3F; read port A and port B at address 0 -> both 0, including on the bypass edge with RF_WR_BYPASS_EN.
5. Reset mid-operation: entry[5]=6'h11; assert rst on the same edge as we=1, waddr=5, wdata=6'h22, re_b=1, raddr_b=5 -> after the edge, rdata_b=0; a subsequent read of 5 returns 0.
6. Parameter sweep: WIDTH=8, DEPTH=16. Write entry[15]=8'hA5 and entry[0]=8'h5A; read both ports simultaneously -> 8'hA5 / 8'h5A. Address wrap is not possible: all 16 addresses are distinct entries, and each is checked with a unique pattern.

Source files
------------

// File: rtl/reg_file_2r1w.sv
// Register file with one write port and two registered read ports (A, B).
// Optional macro RF_WR_BYPASS_EN forwards same-edge write data to a matching read.
module reg_file_2r1w #(
    parameter  int unsigned WIDTH    = 6,
    parameter  int unsigned DEPTH    = 8,
    parameter  int unsigned ZERO_REG = 0,
    localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] wen;
    logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
    logic [WIDTH-1:0] rdata_b_q, rdata_b_d;

    // Zero register and optional bypass are resolved in the mux, ahead of the capture flop.
    function automatic logic [WIDTH-1:0] read_mux(input logic [ADDR_W-1:0] addr);
        logic [WIDTH-1:0] v;
        v = mem_q[addr];
`ifdef RF_WR_BYPASS_EN
        if (we && (addr == waddr)) v = wdata;
`endif
        if ((ZERO_REG != 0) && (addr == '0)) v = '0;
        return v;
    endfunction

    always_comb begin
        wen = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            wen[i] = we && (waddr == ADDR_W'(i)) && !((ZERO_REG != 0) && (i == 0));
        end
    end

    always_comb begin
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        if (re_a) rdata_a_d = read_mux(raddr_a);
        if (re_b) rdata_b_d = read_mux(raddr_b);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wen[i]) mem_q[i] <= wdata;
            end
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Randomized self-checking bench for reg_file_2r1w against an array-based model;
// covers 6x8 (ZERO_REG=0/1) and 8x16 instances, honouring RF_WR_BYPASS_EN.
module tb_reg_file_2r1w;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Small 6x8 instances share one stimulus set
    logic       rst = 1'b1, we = 1'b0, re_a = 1'b0, re_b = 1'b0;
    logic [2:0] waddr = '0, raddr_a = '0, raddr_b = '0;
    logic [5:0] wdata = '0;
    logic [5:0] rda0, rdb0, rda1, rdb1;

    // Wide 8x16 instance
    logic       w_rst = 1'b1, w_we = 1'b0, w_re_a = 1'b0, w_re_b = 1'b0;
    logic [3:0] w_waddr = '0, w_raddr_a = '0, w_raddr_b = '0;
    logic [7:0] w_wdata = '0;
    logic [7:0] w_rda, w_rdb;

    reg_file_2r1w #(.WIDTH(6), .DEPTH(8), .ZERO_REG(0)) u_rf0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rda0),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdb0)
    );

    reg_file_2r1w #(.WIDTH(6), .DEPTH(8), .ZERO_REG(1)) u_rf1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rda1),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdb1)
    );

    reg_file_2r1w #(.WIDTH(8), .DEPTH(16), .ZERO_REG(0)) u_rfw (
        .clk(clk), .rst(w_rst), .we(w_we), .waddr(w_waddr), .wdata(w_wdata),
        .re_a(w_re_a), .raddr_a(w_raddr_a), .rdata_a(w_rda),
        .re_b(w_re_b), .raddr_b(w_raddr_b), .rdata_b(w_rdb)
    );

    // Reference state: index 0 = ZERO_REG off, 1 = ZERO_REG on
    logic [5:0] m [2][8];
    logic [5:0] ea [2];
    logic [5:0] eb [2];
    logic [7:0] mw [16];
    logic [7:0] ewa, ewb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] mread(input int k, input logic [2:0] a);
        if (k == 1 && a == 3'd0) return 6'd0;
`ifdef RF_WR_BYPASS_EN
        if (we && a == waddr) return wdata;
`endif
        return m[k][a];
    endfunction

    function automatic logic [7:0] wread(input logic [3:0] a);
`ifdef RF_WR_BYPASS_EN
        if (w_we && a == w_waddr) return w_wdata;
`endif
        return mw[a];
    endfunction

    task automatic set_s(input logic r, input logic w, input int wa, input int wd,
                         input logic ra, input int aa, input logic rb, input int ab);
        rst = r; we = w; waddr = 3'(wa); wdata = 6'(wd);
        re_a = ra; raddr_a = 3'(aa); re_b = rb; raddr_b = 3'(ab);
    endtask

    task automatic tick_s();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int i = 0; i < 8; i++) m[k][i] = '0;
                ea[k] = '0;
                eb[k] = '0;
            end else begin
                if (re_a) ea[k] = mread(k, raddr_a);
                if (re_b) eb[k] = mread(k, raddr_b);
                if (we && !(k == 1 && waddr == 3'd0)) m[k][waddr] = wdata;
            end
        end
        @(posedge clk);
        #1;
        check("rf0_a", 32'(rda0), 32'(ea[0]));
        check("rf0_b", 32'(rdb0), 32'(eb[0]));
        check("rf1_a", 32'(rda1), 32'(ea[1]));
        check("rf1_b", 32'(rdb1), 32'(eb[1]));
    endtask

    task automatic set_w(input logic r, input logic w, input int wa, input int wd,
                         input logic ra, input int aa, input logic rb, input int ab);
        w_rst = r; w_we = w; w_waddr = 4'(wa); w_wdata = 8'(wd);
        w_re_a = ra; w_raddr_a = 4'(aa); w_re_b = rb; w_raddr_b = 4'(ab);
    endtask

    task automatic tick_w();
        if (w_rst) begin
            for (int i = 0; i < 16; i++) mw[i] = '0;
            ewa = '0;
            ewb = '0;
        end else begin
            if (w_re_a) ewa = wread(w_raddr_a);
            if (w_re_b) ewb = wread(w_raddr_b);
            if (w_we) mw[w_waddr] = w_wdata;
        end
        @(posedge clk);
        #1;
        check("rfw_a", 32'(w_rda), 32'(ewa));
        check("rfw_b", 32'(w_rdb), 32'(ewb));
    endtask

    initial begin
        // 1. Reset for two cycles, with writes and reads requested
        for (int c = 0; c < 2; c++) begin
            set_s(1, 1, c + 1, 6'h3F, 1, c + 1, 1, c + 1);
            set_w(1, 1, c + 1, 8'hFF, 1, c + 1, 1, c + 1);
            tick_s();
            tick_w();
        end
        for (int i = 0; i < 8; i++) begin
            set_s(0, 0, 0, 0, 1, i, 1, 7 - i);
            tick_s();
            check("rst_read", 32'({rda0, rdb0, rda1, rdb1}), 32'd0);
        end

        // 2. Write sweep, crossed read sweep, then hold
        for (int i = 0; i < 8; i++) begin
            set_s(0, 1, i, i + 1, 0, 0, 0, 0);
            tick_s();
        end
        for (int i = 0; i < 8; i++) begin
            set_s(0, 0, 0, 0, 1, i, 1, 7 - i);
            tick_s();
            check("sweep_a", 32'(rda0), 32'(i + 1));
            check("sweep_b", 32'(rdb0), 32'(8 - i));
        end
        for (int c = 0; c < 3; c++) begin
            set_s(0, 1, c, 6'h30 + c, 0, c, 1, c);
            tick_s();
            check("hold_a", 32'(rda0), 32'd8);
        end

        // 3. Read-during-write on address 3
        set_s(0, 1, 3, 6'h05, 0, 0, 0, 0);
        tick_s();
        set_s(0, 1, 3, 6'h2A, 1, 3, 0, 0);
        tick_s();
`ifdef RF_WR_BYPASS_EN
        check("rdw_same_edge", 32'(rda0), 32'h2A);
`else
        check("rdw_same_edge", 32'(rda0), 32'h05);
`endif
        set_s(0, 0, 0, 0, 1, 3, 1, 3);
        tick_s();
        check("rdw_next", 32'(rda0), 32'h2A);

        // 4. Zero register, including the bypass edge
        set_s(0, 1, 0, 6'h3F, 1, 0, 1, 0);
        tick_s();
        check("zr_a_wedge", 32'(rda1), 32'd0);
        check("zr_b_wedge", 32'(rdb1), 32'd0);
        set_s(0, 0, 0, 0, 1, 0, 1, 0);
        tick_s();
        check("zr_a", 32'(rda1), 32'd0);
        check("zr_b", 32'(rdb1), 32'd0);
        check("nozr_a", 32'(rda0), 32'h3F);

        // 5. Reset mid-operation overrides write and read
        set_s(0, 1, 5, 6'h11, 0, 0, 0, 0);
        tick_s();
        set_s(1, 1, 5, 6'h22, 0, 0, 1, 5);
        tick_s();
        check("midrst_b", 32'(rdb0), 32'd0);
        set_s(0, 0, 0, 0, 0, 0, 1, 5);
        tick_s();
        check("midrst_read5", 32'(rdb0), 32'd0);

        // Random traffic on the small instances
        for (int c = 0; c < 400; c++) begin
            set_s(($urandom_range(0, 39) == 0), 1'($urandom), $urandom_range(0, 7),
                  $urandom_range(0, 63), 1'($urandom), $urandom_range(0, 7),
                  1'($urandom), $urandom_range(0, 7));
            tick_s();
        end

        // 6. Wide instance: unique pattern per entry, then A5/5A corners
        for (int i = 0; i < 16; i++) begin
            set_w(0, 1, i, i * 16 + (15 - i), 0, 0, 0, 0);
            tick_w();
        end
        for (int i = 0; i < 16; i++) begin
            set_w(0, 0, 0, 0, 1, i, 1, 15 - i);
            tick_w();
            check("wide_sweep_a", 32'(w_rda), 32'(i * 16 + (15 - i)));
        end
        set_w(0, 1, 15, 8'hA5, 0, 0, 0, 0);
        tick_w();
        set_w(0, 1, 0, 8'h5A, 0, 0, 0, 0);
        tick_w();
        set_w(0, 0, 0, 0, 1, 15, 1, 0);
        tick_w();
        check("wide_a15", 32'(w_rda), 32'hA5);
        check("wide_b0", 32'(w_rdb), 32'h5A);
        for (int c = 0; c < 300; c++) begin
            set_w(($urandom_range(0, 39) == 0), 1'($urandom), $urandom_range(0, 15),
                  $urandom_range(0, 255), 1'($urandom), $urandom_range(0, 15),
                  1'($urandom), $urandom_range(0, 15));
            tick_w();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
